// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: dispatch, CDB snoop and CDB request bundle of the branch resolve unit
interface branch_resolve_unit_if;
  logic        disp_valid;
  logic [31:0] disp_pc;
  logic [2:0]  disp_op;
  logic [31:0] disp_rs1_src;
  logic [31:0] disp_rs1_val;
  logic [31:0] disp_rs2_src;
  logic [31:0] disp_rs2_val;
  logic        full;
  logic        cdb_active;
  logic [31:0] cdb_addr;
  logic [31:0] cdb_val;
  logic        bru_req;
  logic        bru_grant;
  logic [31:0] bru_addr;
  logic [31:0] bru_val;
  modport slave (
    input  disp_valid, disp_pc, disp_op, disp_rs1_src, disp_rs1_val, disp_rs2_src, disp_rs2_val,
    input  cdb_active, cdb_addr, cdb_val, bru_grant,
    output full, bru_req, bru_addr, bru_val
  );
  modport master (
    output disp_valid, disp_pc, disp_op, disp_rs1_src, disp_rs1_val, disp_rs2_src, disp_rs2_val,
    output cdb_active, cdb_addr, cdb_val, bru_grant,
    input  full, bru_req, bru_addr, bru_val
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: in-order branch queue resolving outcomes onto the CDB; BRU_PERF_EN adds resolve/taken counters
module branch_resolve_unit #(
  parameter int BRU_DEPTH   = 4,
  parameter int BRU_DEPTH_W = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  branch_resolve_unit_if.slave bus
`ifdef BRU_PERF_EN
  ,
  output logic [31:0]          perf_resolved,
  output logic [31:0]          perf_taken
`endif
);
  localparam logic [BRU_DEPTH_W:0] FULL_CNT = (BRU_DEPTH_W+1)'(BRU_DEPTH);
  logic                   valid_q [BRU_DEPTH];
  logic [31:0]            pc_q    [BRU_DEPTH];
  logic [2:0]             op_q    [BRU_DEPTH];
  logic [31:0]            src1_q  [BRU_DEPTH];
  logic [31:0]            val1_q  [BRU_DEPTH];
  logic [31:0]            src2_q  [BRU_DEPTH];
  logic [31:0]            val2_q  [BRU_DEPTH];
  logic [BRU_DEPTH_W-1:0] front_q, front_d, rear_q, rear_d;
  logic [BRU_DEPTH_W:0]   count_q, count_d;
  logic [31:0]            h_v1, h_v2;
  logic [2:0]             h_op;
  logic                   cmp, taken, push, pop, fwd1, fwd2;
  // head condition evaluation, request and pointer next-state
  always_comb begin
    h_v1    = val1_q[front_q];
    h_v2    = val2_q[front_q];
    h_op    = op_q[front_q];
    cmp     = h_op[2] ? (h_op[1] ? (h_v1 < h_v2) : ($signed(h_v1) < $signed(h_v2))) : (h_v1 == h_v2);
    taken   = cmp ^ h_op[0];
    push    = rdy_in && bus.disp_valid && !bus.full && !flush_in;
    pop     = bus.bru_req && bus.bru_grant;
    fwd1    = bus.cdb_active && bus.disp_rs1_src != '0 && bus.cdb_addr == bus.disp_rs1_src;
    fwd2    = bus.cdb_active && bus.disp_rs2_src != '0 && bus.cdb_addr == bus.disp_rs2_src;
    front_d = front_q + BRU_DEPTH_W'(pop);
    rear_d  = rear_q + BRU_DEPTH_W'(push);
    count_d = count_q + (BRU_DEPTH_W+1)'(push) - (BRU_DEPTH_W+1)'(pop);
  end
  assign bus.full     = count_q == FULL_CNT;
  assign bus.bru_req  = rdy_in && !flush_in && valid_q[front_q] && src1_q[front_q] == '0 && src2_q[front_q] == '0;
  assign bus.bru_addr = bus.bru_req ? pc_q[front_q] : '0;
  assign bus.bru_val  = {31'b0, bus.bru_req & taken};
  // queue state: flush beats snoop/pop/push; a pushed entry overrides any snoop of its slot
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      front_q <= '0;
      rear_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < BRU_DEPTH; i++) valid_q[i] <= 1'b0;
`ifdef BRU_PERF_EN
      perf_resolved <= '0;
      perf_taken    <= '0;
`endif
    end else if (rdy_in) begin
      if (flush_in) begin
        front_q <= '0;
        rear_q  <= '0;
        count_q <= '0;
        for (int i = 0; i < BRU_DEPTH; i++) valid_q[i] <= 1'b0;
      end else begin
        for (int i = 0; i < BRU_DEPTH; i++) begin
          if (valid_q[i] && bus.cdb_active && src1_q[i] != '0 && src1_q[i] == bus.cdb_addr) begin
            val1_q[i] <= bus.cdb_val;
            src1_q[i] <= '0;
          end
          if (valid_q[i] && bus.cdb_active && src2_q[i] != '0 && src2_q[i] == bus.cdb_addr) begin
            val2_q[i] <= bus.cdb_val;
            src2_q[i] <= '0;
          end
        end
        if (pop) valid_q[front_q] <= 1'b0;
        if (push) begin
          valid_q[rear_q] <= 1'b1;
          pc_q[rear_q]    <= bus.disp_pc;
          op_q[rear_q]    <= bus.disp_op;
          src1_q[rear_q]  <= fwd1 ? '0 : bus.disp_rs1_src;
          val1_q[rear_q]  <= fwd1 ? bus.cdb_val : bus.disp_rs1_val;
          src2_q[rear_q]  <= fwd2 ? '0 : bus.disp_rs2_src;
          val2_q[rear_q]  <= fwd2 ? bus.cdb_val : bus.disp_rs2_val;
        end
        front_q <= front_d;
        rear_q  <= rear_d;
        count_q <= count_d;
`ifdef BRU_PERF_EN
        if (pop) begin
          perf_resolved <= perf_resolved + 32'd1;
          perf_taken    <= perf_taken + 32'(taken);
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed plus randomized checks against a queue-based branch model
module tb_branch_resolve_unit;
  typedef struct {
    logic [31:0] pc;
    logic [2:0]  op;
    logic [31:0] s1, v1, s2, v2;
  } ent_t;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic flush_in = 1'b0;
  int tests = 0;
  int failed = 0;
  ent_t q[$];
  logic [31:0] m_res = 0, m_tk = 0;
  branch_resolve_unit_if bus();
`ifdef BRU_PERF_EN
  logic [31:0] perf_resolved, perf_taken;
  branch_resolve_unit dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in), .bus(bus),
                           .perf_resolved(perf_resolved), .perf_taken(perf_taken));
`else
  branch_resolve_unit dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in), .bus(bus));
`endif
  always #5 clk_in = ~clk_in;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic taken_of(ent_t e);
    case (e.op)
      3'd0: return e.v1 == e.v2;
      3'd1: return e.v1 != e.v2;
      3'd4: return $signed(e.v1) < $signed(e.v2);
      3'd5: return $signed(e.v1) >= $signed(e.v2);
      3'd6: return e.v1 < e.v2;
      3'd7: return e.v1 >= e.v2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic exp_req();
    return rdy_in && !flush_in && q.size() > 0 && q[0].s1 == 0 && q[0].s2 == 0;
  endfunction

  task automatic update(logic er);
    ent_t e;
    logic do_push;
    if (!rdy_in) return;
    if (flush_in) begin
      q.delete();
      return;
    end
    do_push = bus.disp_valid && q.size() < 4;
    foreach (q[i]) begin
      if (bus.cdb_active && q[i].s1 != 0 && q[i].s1 == bus.cdb_addr) begin q[i].v1 = bus.cdb_val; q[i].s1 = 0; end
      if (bus.cdb_active && q[i].s2 != 0 && q[i].s2 == bus.cdb_addr) begin q[i].v2 = bus.cdb_val; q[i].s2 = 0; end
    end
    if (er && bus.bru_grant) begin
      m_res++;
      if (taken_of(q[0])) m_tk++;
      void'(q.pop_front());
    end
    if (do_push) begin
      e.pc = bus.disp_pc; e.op = bus.disp_op;
      e.s1 = bus.disp_rs1_src; e.v1 = bus.disp_rs1_val;
      e.s2 = bus.disp_rs2_src; e.v2 = bus.disp_rs2_val;
      if (bus.cdb_active && e.s1 != 0 && e.s1 == bus.cdb_addr) begin e.v1 = bus.cdb_val; e.s1 = 0; end
      if (bus.cdb_active && e.s2 != 0 && e.s2 == bus.cdb_addr) begin e.v2 = bus.cdb_val; e.s2 = 0; end
      q.push_back(e);
    end
  endtask

  task automatic tick();
    logic er;
    #1;
    er = exp_req();
    check("full", bus.full, q.size() == 4);
    check("req", bus.bru_req, er);
    check("addr", bus.bru_addr, er ? q[0].pc : 32'h0);
    check("val", bus.bru_val, er ? 32'(taken_of(q[0])) : 32'h0);
`ifdef BRU_PERF_EN
    check("perf_res", perf_resolved, m_res);
    check("perf_tk", perf_taken, m_tk);
`endif
    @(posedge clk_in);
    update(er);
    @(negedge clk_in);
  endtask

  task automatic disp(logic [31:0] pc, logic [2:0] op, logic [31:0] s1, logic [31:0] v1, logic [31:0] s2, logic [31:0] v2);
    bus.disp_valid = 1'b1; bus.disp_pc = pc; bus.disp_op = op;
    bus.disp_rs1_src = s1; bus.disp_rs1_val = v1;
    bus.disp_rs2_src = s2; bus.disp_rs2_val = v2;
  endtask

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [31:0] rsrc();
    return ($urandom_range(0, 1) == 0) ? 32'h0 : 32'h80 + 32'($urandom_range(0, 3)) * 4;
  endfunction

  initial begin
    logic [2:0] ops [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    disp(0, 0, 0, 0, 0, 0);
    bus.disp_valid = 0; bus.cdb_active = 0; bus.cdb_addr = 0; bus.cdb_val = 0; bus.bru_grant = 0;
    #1;
    check("rst_full", bus.full, 0);
    check("rst_req", bus.bru_req, 0);
    check("rst_addr", bus.bru_addr, 0);
    check("rst_val", bus.bru_val, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    // BEQ taken with grant held
    bus.bru_grant = 1;
    disp(32'h100, 3'd0, 0, 5, 0, 5);
    tick();
    bus.disp_valid = 0;
    #1;
    check("t1_req", bus.bru_req, 1);
    check("t1_addr", bus.bru_addr, 32'h100);
    check("t1_val", bus.bru_val, 1);
    tick();
    #1 check("t1_empty", bus.bru_req, 0);
    tick();
    // BLT then BLTU waiting on rs1 from the CDB
    for (int k = 0; k < 2; k++) begin
      disp(32'h200, k == 0 ? 3'd4 : 3'd6, 32'h80, 0, 0, 1);
      tick();
      bus.disp_valid = 0;
      bus.cdb_active = 1; bus.cdb_addr = 32'h80; bus.cdb_val = 32'hFFFF_FFFF;
      #1 check("t2_req_wait", bus.bru_req, 0);
      tick();
      bus.cdb_active = 0;
      #1;
      check("t2_req", bus.bru_req, 1);
      check("t2_val", bus.bru_val, k == 0 ? 32'h1 : 32'h0);
      tick();
    end
    // same-cycle forwarding at dispatch
    disp(32'h300, 3'd0, 32'h90, 0, 0, 7);
    bus.cdb_active = 1; bus.cdb_addr = 32'h90; bus.cdb_val = 7;
    tick();
    bus.disp_valid = 0; bus.cdb_active = 0;
    #1;
    check("t3_req", bus.bru_req, 1);
    check("t3_addr", bus.bru_addr, 32'h300);
    tick();
    // fill, drop when full, drain in order
    bus.bru_grant = 0;
    for (int i = 0; i < 4; i++) begin
      disp(32'h10 + 32'(i) * 4, 3'd1, 0, i, 0, 0);
      tick();
    end
    disp(32'h20, 3'd0, 0, 0, 0, 0);
    #1 check("t4_full", bus.full, 1);
    tick();
    bus.disp_valid = 0; bus.bru_grant = 1;
    for (int i = 0; i < 4; i++) begin
      #1 check("t4_order", bus.bru_addr, 32'h10 + 32'(i) * 4);
      tick();
    end
    #1 check("t4_drained", bus.bru_req, 0);
    tick();
    // younger ready entry waits behind a pending head
    disp(32'h400, 3'd0, 32'h84, 0, 0, 0);
    tick();
    disp(32'h404, 3'd0, 0, 0, 0, 0);
    tick();
    bus.disp_valid = 0;
    #1 check("t5_blocked", bus.bru_req, 0);
    tick();
    tick();
    bus.cdb_active = 1; bus.cdb_addr = 32'h84; bus.cdb_val = 0;
    tick();
    bus.cdb_active = 0;
    #1 check("t5_head", bus.bru_addr, 32'h400);
    tick();
    #1 check("t5_next", bus.bru_addr, 32'h404);
    tick();
    tick();
    // flush with simultaneous dispatch
    bus.bru_grant = 0;
    for (int i = 0; i < 3; i++) begin
      disp(32'h500 + 32'(i) * 4, 3'd0, 0, 0, 0, 0);
      tick();
    end
    disp(32'h50C, 3'd0, 0, 0, 0, 0);
    flush_in = 1;
    #1 check("t6_flush_req", bus.bru_req, 0);
    tick();
    flush_in = 0; bus.disp_valid = 0;
    #1;
    check("t6_full", bus.full, 0);
    check("t6_req", bus.bru_req, 0);
    tick();
    // async reset mid-stream
    for (int i = 0; i < 4; i++) begin
      disp(32'h600 + 32'(i) * 4, 3'd0, 0, 0, 0, 0);
      tick();
    end
    bus.disp_valid = 0;
    #2 rst_in = 0;
    #1;
    check("t7_full", bus.full, 0);
    check("t7_req", bus.bru_req, 0);
    check("t7_addr", bus.bru_addr, 0);
    q.delete(); m_res = 0; m_tk = 0;
    @(negedge clk_in);
    rst_in = 1;
    tick();
    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      rdy_in = $urandom_range(0, 9) != 0;
      flush_in = $urandom_range(0, 32) == 0;
      disp(32'h1000 + 32'(n) * 4, ops[$urandom_range(0, 5)], rsrc(), rv(), rsrc(), rv());
      bus.disp_valid = $urandom_range(0, 1);
      bus.bru_grant = $urandom_range(0, 4) < 3;
      bus.cdb_active = rdy_in && $urandom_range(0, 4) < 2;
      bus.cdb_addr = 32'h80 + 32'($urandom_range(0, 3)) * 4;
      bus.cdb_val = rv();
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execution-side producer of branch outcomes on the common data bus (CDB).
- Accepts decoded conditional branches in program order and holds them in an in-order queue.
- Captures pending operands by snooping the CDB, evaluates the branch condition, and broadcasts {addr = branch pc, val[0] = taken} back onto the CDB.
- The branch predictor's in-order outcome queue consumes these broadcasts, so results leave strictly in dispatch order.

Parameters:
- BRU_DEPTH, 4, number of queue entries (power of two).
- BRU_DEPTH_W, 2, log2(BRU_DEPTH); pointer width.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; low freezes all state.
- flush_in  input  1  predict_fail from the predictor; discards all entries.
- disp_valid  input  1  branch dispatch strobe.
- disp_pc  input  32  branch instruction address; nonzero.
- disp_op  input  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- disp_rs1_src  input  32  producer address of rs1; 0 means the value is present.
- disp_rs1_val  input  32  rs1 value, valid when src==0.
- disp_rs2_src  input  32  as rs1.
- disp_rs2_val  input  32  as rs1.
- full  output  1  queue full; dispatch is ignored while high.
- cdb_active  input  1  CDB broadcast valid.
- cdb_addr  input  32  broadcasting producer address.
- cdb_val  input  32  broadcast value.
- bru_req  output  1  head entry resolved; requests the CDB.
- bru_grant  input  1  CDB arbiter grant; the broadcast occurs in this cycle.
- bru_addr  output  32  head pc while bru_req is high, else 0.
- bru_val  output  32  {31'b0, taken} while bru_req is high, else 0.

Behaviour:
- Reset (rst_in=0, async): front=rear=count=0, all entries invalid. full=0, bru_req=0, bru_addr=0, bru_val=0.
- Entry fields: valid, pc, op, src1, val1, src2, val2. An operand is ready when its src==0.
- Dispatch:
  - Occurs on a rising edge with rdy_in && disp_valid && !full && !flush_in.
  - Writes the entry at rear; rear wraps BRU_DEPTH-1 -> 0; count+1.
  - Same-cycle forwarding: if cdb_active and cdb_addr==disp_rsX_src (and src!=0), store the CDB value with src=0.
- Snoop: every rdy cycle, each valid entry whose srcX!=0 && srcX==cdb_addr && cdb_active latches valX=cdb_val and sets srcX=0.
- full = (count==BRU_DEPTH). A dispatch while full is dropped even if a pop happens in the same cycle.
- Resolve, combinational on head fields:
  - EQ/NE use val1==val2.
  - LT/GE use a signed compare.
  - LTU/GEU use an unsigned compare.
  - taken is 1 bit.
- bru_req = rdy_in && !flush_in && head valid && head src1==0 && head src2==0. The condition uses stored values only; a CDB value arriving this cycle makes bru_req rise next cycle.
- Pop: on an edge with bru_req && bru_grant, invalidate the head, front+1 with wrap, count-1. The next entry may request in the following cycle, giving at most one broadcast per cycle.
- bru_req stays high and bru_addr/bru_val stay stable until granted. Only the head may request; younger ready entries wait.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- flush_in (synchronous, priority over dispatch, pop and snoop): on the next edge all entries are invalid and front=rear=count=0; bru_req=0 during the flush cycle.
- rdy_in=0: no state change, bru_req=0, CDB ignored. Operands broadcast during !rdy_in are lost; the CDB contract guarantees no broadcasts while rdy_in is low.
- Reset asserted mid-operation: immediate clear regardless of clock or rdy_in.

Optional Feature:
- Macro: BRU_PERF_EN.
- When defined:
  - Adds outputs perf_resolved[31:0] and perf_taken[31:0].
  - perf_resolved increments on each pop; perf_taken increments on each pop with taken=1.
  - Both counters wrap at 2^32, clear on reset, and are not cleared by flush_in.
- When undefined: no counters and no ports; behaviour is otherwise identical.

Test Plan:
- Dispatch BEQ pc=0x100, both src=0, vals 5/5, grant held high -> bru_req the next cycle; bru_addr=0x100, bru_val=1; queue empty after the grant.
- Dispatch BLT pc=0x200, rs1 src=0x80, rs2=0; then cdb_active addr=0x80 val=0xFFFFFFFF against rs2=1 -> bru_req one cycle after the broadcast, bru_val=1. The same operands under BLTU give 0.
- Dispatch pc=0x300 in the same cycle as cdb_active addr=0x90 matching rs1_src=0x90 -> value forwarded; bru_req next cycle with no further broadcast.
- Fill 4 entries (pcs 0x10/0x14/0x18/0x1C), all ready, grant withheld -> full=1, 5th dispatch dropped. Then grant every cycle -> addrs 0x10, 0x14, 0x18, 0x1C in order, pointers wrap.
- Head not ready, entry 2 ready, grant high -> no bru_req; entry 2 is not broadcast before the head.
- 3 entries queued, flush_in pulse with simultaneous disp_valid -> count=0, full=0, bru_req=0, the dispatch is dropped. An async rst_in low mid-stream clears everything without a clock edge.
